// File: rtl/feature_burst_buffer_pkg.sv
// rtl/feature_burst_buffer_pkg.sv - constants, level-update opcodes and helpers for the feature burst buffer
`include "parameters.v"

package feature_burst_buffer_pkg;

    localparam int FBB_DATA_WIDTH = `MEM_DATA_WIDTH;
    localparam int FBB_BURST_LEN = `BURST_LEN;
    localparam logic [31:0] FBB_BURST_STRIDE = `FEATURE_BURST_STRIDE;

    // {write accepted, read accepted} decides how the occupancy moves
    typedef enum logic [1:0] {
        FBB_OP_IDLE = 2'b00,
        FBB_OP_POP  = 2'b01,
        FBB_OP_PUSH = 2'b10,
        FBB_OP_BOTH = 2'b11
    } fbb_op_e;

    function automatic logic burst_space(input int unsigned depth, input int unsigned lvl,
                                         input int unsigned burst_len);
        return (depth - lvl) >= burst_len;
    endfunction

endpackage

// File: rtl/parameters.v
// rtl/parameters.v - shared accelerator constants (data width, DDR burst length, feature stride)
`ifndef PARAMETERS_V
`define PARAMETERS_V
`define MEM_DATA_WIDTH 64
`define BURST_LEN 64
`define FEATURE_BURST_STRIDE 32'h1000
`endif

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port RAM with one write port and a registered, enabled read port
module sdp_ram #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  system_clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge system_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/feature_burst_buffer.sv
// rtl/feature_burst_buffer.sv - FWFT burst buffer between the DDR read controller and the compute array
`include "parameters.v"

module feature_burst_buffer
    import feature_burst_buffer_pkg::*;
#(
    parameter int MEM_DATA_WIDTH = `MEM_DATA_WIDTH,
    parameter int DEPTH          = 256,
    parameter int BURST_LEN      = FBB_BURST_LEN
) (
    input  logic                      system_clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [MEM_DATA_WIDTH-1:0] wr_data,
    input  logic                      wr_valid,
    output logic                      buffer_ready,
    output logic [MEM_DATA_WIDTH-1:0] rd_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic                      rd_last,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(BURST_LEN);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [BW-1:0] beat_cnt;
    logic          out_valid;
    logic          do_rd;
    logic          do_wr;
    logic          ram_we;
    logic          ram_re;
    logic [LW-1:0] ram_words;
    fbb_op_e       op;

    assign do_rd = out_valid & rd_ready;
    // a full buffer still takes a write when the head leaves in the same cycle
    assign do_wr = wr_valid & ((level != LW'(DEPTH)) | do_rd);

    // the RAM read register doubles as the output stage, so prefetch only when it is free or draining
    assign ram_words = level - LW'(out_valid);
    assign ram_re    = rst_n & ~flush & (ram_words != '0) & (~out_valid | do_rd);
    assign ram_we    = rst_n & ~flush & do_wr;

    always_comb begin
        op = fbb_op_e'({do_wr, do_rd});
    end

    sdp_ram #(
        .DATA_WIDTH(MEM_DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(AW)
    ) u_sdp_ram (
        .system_clk(system_clk),
        .we        (ram_we),
        .waddr     (wr_ptr),
        .wdata     (wr_data),
        .re        (ram_re),
        .raddr     (rd_ptr),
        .rdata     (rd_data)
    );

    always_ff @(posedge system_clk) begin
        if (!rst_n || flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            beat_cnt     <= '0;
            out_valid    <= 1'b0;
            level        <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (ram_re) begin
                rd_ptr    <= rd_ptr + AW'(1);
                out_valid <= 1'b1;
            end else if (do_rd) begin
                out_valid <= 1'b0;
            end
            if (do_rd) begin
                beat_cnt <= beat_cnt + BW'(1);
            end
            case (op)
                FBB_OP_PUSH: level <= level + LW'(1);
                FBB_OP_POP:  level <= level - LW'(1);
                default:     level <= level;
            endcase
            if (wr_valid && !do_wr) begin
                overflow_err <= 1'b1;
            end
        end
    end

    assign rd_valid     = out_valid;
    assign rd_last      = out_valid & (beat_cnt == BW'(BURST_LEN - 1));
    assign buffer_ready = burst_space(DEPTH, 32'(level), BURST_LEN);

endmodule

// File: doc/feature_burst_buffer.md
FEATURE_BURST_BUFFER -- requirements
Module: feature_burst_buffer

Interface
REQ-001 SHALL have parameter MEM_DATA_WIDTH, default `MEM_DATA_WIDTH, meaning the data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, meaning storage depth in words; it is a power of two and at least 2*BURST_LEN.
REQ-003 SHALL have parameter BURST_LEN, default 64, meaning beats per DDR read burst (arlen 63).
REQ-004 SHALL have port system_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port flush, input, 1 bit: single-cycle pulse that discards all contents (driven by load_feature_begin).
REQ-007 SHALL have port wr_data, input, MEM_DATA_WIDTH bits: burst beat from the DDR read controller.
REQ-008 SHALL have port wr_valid, input, 1 bit: wr_data is valid this cycle (no backpressure).
REQ-009 SHALL have port buffer_ready, output, 1 bit: space exists for one full burst (feeds feature_buffer_N_ready).
REQ-010 SHALL have port rd_data, output, MEM_DATA_WIDTH bits: head word to the compute array.
REQ-011 SHALL have port rd_valid, output, 1 bit: rd_data is valid.
REQ-012 SHALL have port rd_ready, input, 1 bit: consumer accepts rd_data.
REQ-013 SHALL have port rd_last, output, 1 bit: qualified by rd_valid; marks the last beat of each BURST_LEN group.
REQ-014 SHALL have port level, output, $clog2(DEPTH)+1 bits: words held, including the output stage.
REQ-015 SHALL have port overflow_err, output, 1 bit: sticky flag, set when a write is dropped.

Function
REQ-016 SHALL store words in FIFO order; a write occurs on wr_valid, a read on rd_valid & rd_ready.
REQ-017 SHALL drive buffer_ready combinationally from registered level: 1 when (DEPTH - level) >= BURST_LEN, otherwise 0.
REQ-018 SHALL be first-word-fall-through: when empty, a word written in cycle N SHALL give rd_valid=1 with that word in cycle N+2.
REQ-019 SHALL accept back-to-back reads at 1 word per cycle when level >= 2, with no bubbles.
REQ-020 SHALL hold rd_data and rd_last stable while rd_valid=1 and rd_ready=0.
REQ-021 SHALL update level as +1 on a write only, -1 on a read only, and leave it unchanged when both happen in the same cycle.
REQ-022 SHALL drop a write when level == DEPTH and no read occurs that cycle; in that case it SHALL set overflow_err and leave the contents intact.
REQ-023 SHALL wrap the write and read pointers modulo DEPTH, with no gap at wrap.
REQ-024 SHALL keep a beat counter of $clog2(BURST_LEN) bits that increments on each read handshake and wraps to 0.
REQ-025 SHALL assert rd_last when the beat counter equals BURST_LEN-1.
REQ-026 SHALL give flush priority over all other events: in the cycle after flush, level=0, rd_valid=0, beat counter=0, overflow_err=0 and pointers=0.
REQ-027 SHALL discard a write and ignore a read that occur in the flush cycle.
REQ-028 SHALL keep rd_valid=0 when empty; reads attempted while empty have no effect.

Reset
REQ-029 SHALL, when rst_n=0 at a clock edge, set rd_valid=0, rd_last=0, level=0, overflow_err=0, buffer_ready=1 (from level=0), and pointers and beat counter=0.
REQ-030 SHALL reset as defined in REQ-029 when reset is asserted mid-burst; beats that arrive during reset are lost, and the RAM contents need no reset.
REQ-031 SHALL leave rd_data unspecified while rd_valid=0.

Structure
REQ-032 SHALL take BURST_LEN (64) and the feature burst stride (32'h1000) from the shared parameters.v include as constants, not as local literals.
REQ-033 SHALL place storage in one sub-module, sdp_ram: simple dual-port, one write port, one registered read port with read enable, and no reset.
REQ-034 SHALL keep pointers, level, the prefetch/output stage and the beat counter in feature_burst_buffer.

Verification
REQ-035 SHALL cover: reset, then 64 writes of values 0..63 with rd_ready=1 -> first rd_valid 2 cycles after the first write, words 0..63 in order, rd_last only on word 63, final level=0.
REQ-036 SHALL cover: rd_ready=0 and 3 bursts of 64 words -> buffer_ready=1 after bursts 1-2; after burst 3 level=192 and buffer_ready=1; after a 4th burst level=256 and buffer_ready=0.
REQ-037 SHALL cover: level=256, one further write -> word dropped, overflow_err=1 and held, level stays 256; then a flush -> overflow_err=0 and level=0 the next cycle.
REQ-038 SHALL cover: level=10 with simultaneous write and read for 20 cycles -> level stays 10 and the data sequence is continuous.
REQ-039 SHALL cover: 300 words written and read in chunks to cross the pointer wrap -> output equals input and rd_last on beats 63, 127, 191, 255.
REQ-040 SHALL cover: rst_n=0 asserted after beat 30 of a burst -> the next cycle has level=0, rd_valid=0 and buffer_ready=1; a new burst then reads back correctly with rd_last on beat 63.
